instr_mem_loader: RTL and testbench

Byte-stream boot loader that writes a program image into the 128 x 8 instruction memory the single-cycle 16-bit CPU fetches from. The CPU is the reader of that memory; this block is its writer. It accepts a framed image over a valid/ready byte interface and checks header, bounds, alignment and checksum. On success it releases the CPU and presents the start PC; on any failure it holds the CPU in a sticky error state.

---
 rtl/instr_mem_loader_pkg.sv | 66 ++++++
 rtl/instr_mem_loader.sv | 201 ++++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_pkg
// Shared types and constants for the instruction-memory boot loader:
// FSM state encoding, error codes, frame header size and the header check
// helper used when the length field completes.
// -----------------------------------------------------------------------------
package instr_mem_loader_pkg;

    localparam int unsigned DEF_MEM_BYTES = 128;
    localparam int unsigned DEF_ADDR_W    = 7;
    localparam int unsigned HDR_BYTES     = 4;
    localparam int unsigned PC_W          = 16;
    localparam int unsigned BYTE_W        = 8;

    // Loader FSM states, in frame order; RUN and ERR are terminal until Restart.
    typedef enum logic [2:0] {
        ADDR_HI = 3'd0,
        ADDR_LO = 3'd1,
        LEN_HI  = 3'd2,
        LEN_LO  = 3'd3,
        DATA    = 3'd4,
        CSUM    = 3'd5,
        RUN     = 3'd6,
        ERR     = 3'd7
    } state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_LEN    = 2'd0;
    localparam err_code_t ERR_BOUNDS = 2'd1;
    localparam err_code_t ERR_ALIGN  = 2'd2;
    localparam err_code_t ERR_CSUM   = 2'd3;

    // Result of the header check: fail flag plus the highest-priority code.
    typedef struct packed {
        logic      fail;
        err_code_t code;
    } hdr_chk_t;

    // Validate start address and byte count against the memory size.
    // Priority: length > bounds > alignment. Sum is done in 17 bits so a
    // start near 0xFFFF cannot wrap back into range.
    function automatic hdr_chk_t check_header(
        input logic [PC_W-1:0] start,
        input logic [PC_W-1:0] n,
        input logic [PC_W:0]   mem_bytes
    );
        hdr_chk_t        r;
        logic [PC_W:0]   end_addr;
        r.fail   = 1'b0;
        r.code   = ERR_LEN;
        end_addr = {1'b0, start} + {1'b0, n};
        if ((n == '0) || ({1'b0, n} > mem_bytes)) begin
            r.fail = 1'b1;
            r.code = ERR_LEN;
        end else if (end_addr > mem_bytes) begin
            r.fail = 1'b1;
            r.code = ERR_BOUNDS;
        end else if (start[0] || n[0]) begin
            r.fail = 1'b1;
            r.code = ERR_ALIGN;
        end
        return r;
    endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
// Byte-stream boot loader that writes a framed program image into the
// 128 x 8 instruction memory, then releases the CPU at the header start PC.
// Frame (big-endian): ADDR_HI ADDR_LO LEN_HI LEN_LO, N payload bytes, and
// one checksum byte equal to the XOR of the payload.
//
// Ports:
//   Clock      in   rising-edge clock
//   Reset      in   async active-high reset, returns to ADDR_HI
//   InByte     in   stream byte
//   InValid    in   InByte valid
//   InReady    out  byte accepted this cycle when InValid=1 (registered)
//   Restart    in   sync restart from RUN or ERR, ignored elsewhere
//   MemWrEn    out  memory byte write strobe (one cycle per payload byte)
//   MemAddr    out  memory byte address
//   MemWrData  out  memory write byte
//   CpuRun     out  1 = CPU may run
//   StartPc    out  start address from header, valid while CpuRun=1
//   Error      out  sticky load failure
//   ErrCode    out  0 length, 1 bounds, 2 alignment, 3 checksum
// -----------------------------------------------------------------------------
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
    parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [7:0]        InByte,
    input  logic              InValid,
    output logic              InReady,
    input  logic              Restart,
    output logic              MemWrEn,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [7:0]        MemWrData,
    output logic              CpuRun,
    output logic [15:0]       StartPc,
    output logic              Error,
    output logic [1:0]        ErrCode
);

    // Remaining-byte counter must hold the full memory size (N = MEM_BYTES).
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t              state_q, state_d;

    // Datapath registers
    logic [PC_W-1:0]     start_q,     start_d;
    logic [BYTE_W-1:0]   len_hi_q,    len_hi_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [BYTE_W-1:0]   xor_q,       xor_d;
    logic [ADDR_W-1:0]   wr_ptr_q,    wr_ptr_d;

    // Next values of the registered outputs
    logic                in_ready_d;
    logic                mem_wr_en_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [BYTE_W-1:0]   mem_wr_data_d;
    logic                cpu_run_d;
    logic [PC_W-1:0]     start_pc_d;
    logic                error_d;
    err_code_t           err_code_d;

    logic                accept;
    logic [PC_W-1:0]     hdr_len;
    hdr_chk_t            hdr_chk;
    logic                last_byte;
    logic                csum_ok;

    // InReady is a flop, so accept never depends combinationally on itself.
    assign accept    = InValid & InReady;
    assign hdr_len   = {len_hi_q, InByte};
    assign hdr_chk   = check_header(start_q, hdr_len, (PC_W+1)'(MEM_BYTES));
    assign last_byte = (remaining_q == CNT_W'(1));
    assign csum_ok   = (InByte == xor_q);

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ADDR_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ADDR_HI: if (accept) state_d = ADDR_LO;
            ADDR_LO: if (accept) state_d = LEN_HI;
            LEN_HI:  if (accept) state_d = LEN_LO;
            LEN_LO:  if (accept) state_d = hdr_chk.fail ? ERR : DATA;
            DATA:    if (accept && last_byte) state_d = CSUM;
            CSUM:    if (accept) state_d = csum_ok ? RUN : ERR;
            RUN:     if (Restart) state_d = ADDR_HI;
            ERR:     if (Restart) state_d = ADDR_HI;
            default: state_d = ADDR_HI;
        endcase
    end

    // Output and datapath next-value logic
    always_comb begin
        start_d       = start_q;
        len_hi_d      = len_hi_q;
        remaining_d   = remaining_q;
        xor_d         = xor_q;
        wr_ptr_d      = wr_ptr_q;
        mem_wr_en_d   = 1'b0;
        mem_addr_d    = MemAddr;
        mem_wr_data_d = MemWrData;
        start_pc_d    = StartPc;
        err_code_d    = ErrCode;

        // Status outputs follow the state being entered, giving one-cycle latency.
        in_ready_d = (state_d != RUN) && (state_d != ERR);
        cpu_run_d  = (state_d == RUN);
        error_d    = (state_d == ERR);

        case (state_q)
            ADDR_HI: if (accept) start_d[15:8] = InByte;
            ADDR_LO: if (accept) start_d[7:0]  = InByte;
            LEN_HI:  if (accept) len_hi_d      = InByte;
            LEN_LO: begin
                if (accept) begin
                    if (hdr_chk.fail) begin
                        err_code_d = hdr_chk.code;
                    end else begin
                        remaining_d = CNT_W'(hdr_len);
                        wr_ptr_d    = start_q[ADDR_W-1:0];
                        xor_d       = '0;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    mem_wr_en_d   = 1'b1;
                    mem_addr_d    = wr_ptr_q;
                    mem_wr_data_d = InByte;
                    wr_ptr_d      = wr_ptr_q + ADDR_W'(1);
                    remaining_d   = remaining_q - CNT_W'(1);
                    xor_d         = xor_q ^ InByte;
                end
            end
            CSUM: begin
                if (accept) begin
                    if (csum_ok) begin
                        start_pc_d = start_q;
                    end else begin
                        err_code_d = ERR_CSUM;
                    end
                end
            end
            RUN, ERR: begin
                // Restart re-arms the loader with a clean accumulator and status.
                if (Restart) begin
                    xor_d       = '0;
                    remaining_d = '0;
                    err_code_d  = ERR_LEN;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            start_q     <= '0;
            len_hi_q    <= '0;
            remaining_q <= '0;
            xor_q       <= '0;
            wr_ptr_q    <= '0;
            InReady     <= 1'b1;
            MemWrEn     <= 1'b0;
            MemAddr     <= '0;
            MemWrData   <= '0;
            CpuRun      <= 1'b0;
            StartPc     <= '0;
            Error       <= 1'b0;
            ErrCode     <= ERR_LEN;
        end else begin
            start_q     <= start_d;
            len_hi_q    <= len_hi_d;
            remaining_q <= remaining_d;
            xor_q       <= xor_d;
            wr_ptr_q    <= wr_ptr_d;
            InReady     <= in_ready_d;
            MemWrEn     <= mem_wr_en_d;
            MemAddr     <= mem_addr_d;
            MemWrData   <= mem_wr_data_d;
            CpuRun      <= cpu_run_d;
            StartPc     <= start_pc_d;
            Error       <= error_d;
            ErrCode     <= err_code_d;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
// Self-checking bench for instr_mem_loader: hand-written sequences for the
// multi-cycle cases plus a table of header/checksum vectors. Expected memory
// writes are queued when a payload byte is driven and popped when MemWrEn
// fires. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

    localparam int unsigned AW = 7;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [7:0]    InByte;
    logic          InValid;
    logic          InReady;
    logic          Restart;
    logic          MemWrEn;
    logic [AW-1:0] MemAddr;
    logic [7:0]    MemWrData;
    logic          CpuRun;
    logic [15:0]   StartPc;
    logic          Error;
    logic [1:0]    ErrCode;

    instr_mem_loader #(.MEM_BYTES(128), .ADDR_W(AW)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .InByte    (InByte),
        .InValid   (InValid),
        .InReady   (InReady),
        .Restart   (Restart),
        .MemWrEn   (MemWrEn),
        .MemAddr   (MemAddr),
        .MemWrData (MemWrData),
        .CpuRun    (CpuRun),
        .StartPc   (StartPc),
        .Error     (Error),
        .ErrCode   (ErrCode)
    );

    always #5 Clock = ~Clock;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    logic [14:0]  exp_q[$];     // {addr, data} of expected writes
    int           wr_cyc[$];    // cycle numbers at which writes were seen
    logic [7:0]   payload[$];

    typedef struct {
        logic [15:0] start;
        logic [15:0] len;
        logic [7:0]  seed;
        logic [7:0]  cdelta;
        logic        exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_write();
        logic [14:0] e;
        if (MemWrEn === 1'b1) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mem_write_unexpected: addr 0x%0h data 0x%0h, required no write (cycle %0d)",
                         MemAddr, MemWrData, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("mem_write", 32'({MemAddr, MemWrData}), 32'(e));
            end
        end
    endtask

    // One clock edge, landing mid-cycle where outputs are stable.
    task automatic step();
        @(posedge Clock);
        cyc++;
        @(negedge Clock);
        check_write();
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall);
        bit took;
        int waited;
        InValid = 1'b0;
        for (int s = 0; s < stall; s++) step();
        InByte = b;
        InValid = 1'b1;
        took = 1'b0;
        waited = 0;
        while (!took && waited < 20) begin
            took = InReady;
            step();
            waited++;
        end
        InValid = 1'b0;
        if (!took) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: byte 0x%0h not accepted, InReady 0, required 1", b);
        end
    endtask

    task automatic send_hdr(input logic [15:0] start, input logic [15:0] len, input int stall);
        send_byte(start[15:8], stall);
        send_byte(start[7:0], stall);
        send_byte(len[15:8], stall);
        send_byte(len[7:0], stall);
    endtask

    // Payload from the global queue, then checksum XOR cdelta.
    task automatic send_body(input logic [15:0] start, input logic [7:0] cdelta, input int stall);
        logic [7:0] cs;
        cs = 8'h00;
        for (int i = 0; i < payload.size(); i++) begin
            exp_q.push_back({7'(start + 16'(i)), payload[i]});
            send_byte(payload[i], stall);
            cs = cs ^ payload[i];
        end
        chk("cpu_held_before_csum", 32'(CpuRun), 32'd0);
        send_byte(cs ^ cdelta, stall);
    endtask

    task automatic check_run(input logic [15:0] start);
        chk("run_cpurun", 32'(CpuRun), 32'd1);
        chk("run_startpc", 32'(StartPc), 32'(start));
        chk("run_error", 32'(Error), 32'd0);
        chk("run_inready", 32'(InReady), 32'd0);
        chk("run_writes_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_err(input logic [1:0] code);
        chk("err_error", 32'(Error), 32'd1);
        chk("err_code", 32'(ErrCode), 32'(code));
        chk("err_cpurun", 32'(CpuRun), 32'd0);
        chk("err_inready", 32'(InReady), 32'd0);
        chk("err_writes_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_restart();
        Restart = 1'b1;
        step();
        Restart = 1'b0;
        chk("restart_cpurun", 32'(CpuRun), 32'd0);
        chk("restart_inready", 32'(InReady), 32'd1);
        chk("restart_error", 32'(Error), 32'd0);
        chk("restart_errcode", 32'(ErrCode), 32'd0);
    endtask

    task automatic check_reset_vals();
        chk("rst_inready", 32'(InReady), 32'd1);
        chk("rst_memwren", 32'(MemWrEn), 32'd0);
        chk("rst_memaddr", 32'(MemAddr), 32'd0);
        chk("rst_memwrdata", 32'(MemWrData), 32'd0);
        chk("rst_cpurun", 32'(CpuRun), 32'd0);
        chk("rst_startpc", 32'(StartPc), 32'd0);
        chk("rst_error", 32'(Error), 32'd0);
        chk("rst_errcode", 32'(ErrCode), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // start, len, payload seed, checksum xor, expect error, expected code
        vecs[0]  = '{16'h0000, 16'd2,   8'h11, 8'h00, 1'b0, 2'd0};
        vecs[1]  = '{16'h007C, 16'd4,   8'h3C, 8'h00, 1'b0, 2'd0};  // ends exactly at 128
        vecs[2]  = '{16'h0000, 16'd128, 8'hA5, 8'h00, 1'b0, 2'd0};  // whole memory
        vecs[3]  = '{16'h0010, 16'd6,   8'h5A, 8'h01, 1'b1, 2'd3};  // bad checksum
        vecs[4]  = '{16'h007E, 16'd4,   8'h00, 8'h00, 1'b1, 2'd1};
        vecs[5]  = '{16'h0001, 16'd2,   8'h00, 8'h00, 1'b1, 2'd2};
        vecs[6]  = '{16'h0000, 16'd0,   8'h00, 8'h00, 1'b1, 2'd0};
        vecs[7]  = '{16'h0000, 16'd129, 8'h00, 8'h00, 1'b1, 2'd0};
        vecs[8]  = '{16'h0001, 16'd0,   8'h00, 8'h00, 1'b1, 2'd0};  // length beats alignment
        vecs[9]  = '{16'h007F, 16'd4,   8'h00, 8'h00, 1'b1, 2'd1};  // bounds beats alignment
        vecs[10] = '{16'h0004, 16'd3,   8'h00, 8'h00, 1'b1, 2'd2};  // odd length
        vecs[11] = '{16'hFFFE, 16'd4,   8'h00, 8'h00, 1'b1, 2'd1};  // no 16-bit wrap
        vecs[12] = '{16'h0080, 16'd2,   8'h00, 8'h00, 1'b1, 2'd1};

        Reset = 1'b1;
        InValid = 1'b0;
        InByte = 8'h00;
        Restart = 1'b0;
        step();
        step();
        check_reset_vals();
        Reset = 1'b0;
        step();

        // Good image; checksum of 90 05 F1 02 is 0x66
        payload = '{8'h90, 8'h05, 8'hF1, 8'h02};
        wr_cyc.delete();
        send_hdr(16'h000A, 16'd4, 0);
        send_body(16'h000A, 8'h00, 0);
        check_run(16'h000A);
        chk("good_write_count", 32'(wr_cyc.size()), 32'd4);
        if (wr_cyc.size() == 4)
            for (int i = 1; i < 4; i++)
                chk("good_write_consecutive", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd1);

        // Bytes offered in RUN are refused
        InByte = 8'hAA;
        InValid = 1'b1;
        repeat (3) step();
        InValid = 1'b0;
        chk("run_ignores_input", 32'(CpuRun), 32'd1);
        do_restart();

        // Bad checksum: last byte 0x17 (0x66 ^ 0x71)
        send_hdr(16'h000A, 16'd4, 0);
        send_body(16'h000A, 8'h71, 0);
        check_err(2'd3);
        do_restart();

        // Stalled image, with a Restart pulse mid-header that must be ignored
        wr_cyc.delete();
        send_byte(8'h00, 3);
        send_byte(8'h0A, 3);
        Restart = 1'b1;
        step();
        Restart = 1'b0;
        send_byte(8'h00, 3);
        send_byte(8'h04, 3);
        send_body(16'h000A, 8'h00, 3);
        check_run(16'h000A);
        chk("stall_write_count", 32'(wr_cyc.size()), 32'd4);
        do_restart();

        // Reset after two payload bytes
        send_hdr(16'h000A, 16'd4, 0);
        exp_q.push_back({7'd10, 8'h90});
        send_byte(8'h90, 0);
        exp_q.push_back({7'd11, 8'h05});
        send_byte(8'h05, 0);
        Reset = 1'b1;
        #1;
        check_reset_vals();
        step();
        Reset = 1'b0;
        step();
        chk("post_reset_writes_done", 32'(exp_q.size()), 32'd0);
        send_hdr(16'h000A, 16'd4, 0);
        send_body(16'h000A, 8'h00, 0);
        check_run(16'h000A);

        // Restart from RUN, second image at 0x0020
        do_restart();
        payload = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        send_hdr(16'h0020, 16'd6, 0);
        send_body(16'h0020, 8'h00, 0);
        check_run(16'h0020);
        do_restart();

        // Table of header/checksum vectors
        for (int v = 0; v < 13; v++) begin
            send_hdr(vecs[v].start, vecs[v].len, 0);
            if (vecs[v].exp_err && vecs[v].exp_code != 2'd3) begin
                step();
                check_err(vecs[v].exp_code);
            end else begin
                payload.delete();
                for (int i = 0; i < int'(vecs[v].len); i++)
                    payload.push_back(8'(int'(vecs[v].seed) + i * 37));
                send_body(vecs[v].start, vecs[v].cdelta, 0);
                if (vecs[v].exp_err) check_err(vecs[v].exp_code);
                else                 check_run(vecs[v].start);
            end
            do_restart();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
